refresh_arbiter: RTL and testbench

REFRESH_ARBITER -- requirements
Module: refresh_arbiter

---
 rtl/refresh_pkg.sv | 15 +
 rtl/refresh_timer.sv | 57 +++++
 rtl/refresh_arbiter.sv | 93 +++++++++
 tb/tb_refresh_arbiter.sv | 318 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/refresh_pkg.sv
// Shared constants for the SDRAM refresh/Zorro arbiter: arbiter state encoding
// and default timing parameters.
package refresh_pkg;

    localparam int DEFAULT_REFI_CYCLES = 390;
    localparam int DEFAULT_MAX_DEBT    = 8;
    localparam int DEBT_W              = 4;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_ZORRO   = 2'd1,
        ST_REFRESH = 2'd2
    } arb_state_t;

endpackage

// File: rtl/refresh_timer.sv
// Refresh interval counter and owed-refresh (debt) accounting with a sticky
// overflow flag for ticks lost at full debt.
module refresh_timer
    import refresh_pkg::*;
#(
    parameter int REFI_CYCLES = DEFAULT_REFI_CYCLES,
    parameter int MAX_DEBT    = DEFAULT_MAX_DEBT
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              i_enable,
    input  logic              i_dec,
    output logic [DEBT_W-1:0] o_debt,
    output logic              o_overflow
);

    localparam int                CNT_W    = (REFI_CYCLES > 1) ? $clog2(REFI_CYCLES) : 1;
    localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(REFI_CYCLES - 1);
    localparam logic [DEBT_W-1:0] DEBT_MAX = DEBT_W'(MAX_DEBT);

    logic [CNT_W-1:0]  r_cnt;
    logic [DEBT_W-1:0] r_debt;
    logic              r_overflow;
    logic              w_tick;
    logic              w_dec;

    // Tick is qualified by enable so a frozen counter cannot stretch it.
    assign w_tick = i_enable && (r_cnt == CNT_LAST);
    assign w_dec  = i_dec && (r_debt != '0);

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_cnt <= '0;
        end else if (i_enable) begin
            r_cnt <= w_tick ? '0 : r_cnt + CNT_W'(1);
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_debt     <= '0;
            r_overflow <= 1'b0;
        end else if (w_tick && !w_dec) begin
            if (r_debt == DEBT_MAX) begin
                r_overflow <= 1'b1;
            end else begin
                r_debt <= r_debt + DEBT_W'(1);
            end
        end else if (w_dec && !w_tick) begin
            r_debt <= r_debt - DEBT_W'(1);
        end
    end

    assign o_debt     = r_debt;
    assign o_overflow = r_overflow;

endmodule

// File: rtl/refresh_arbiter.sv
// Arbitrates SDRAM ownership between Zorro III RAM cycles and auto-refresh,
// forcing refresh once owed refreshes reach MAX_DEBT.
module refresh_arbiter
    import refresh_pkg::*;
#(
    parameter int REFI_CYCLES = DEFAULT_REFI_CYCLES,
    parameter int MAX_DEBT    = DEFAULT_MAX_DEBT
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              init_done,
    input  logic              zr_req,
    input  logic              zr_done,
    input  logic              ref_done,
    output logic              zr_gnt,
    output logic              ref_gnt,
    output logic [DEBT_W-1:0] debt,
    output logic              overflow
);

    arb_state_t        r_state;
    arb_state_t        w_state_next;
    logic              r_zr_gnt;
    logic              r_ref_gnt;
    logic [DEBT_W-1:0] w_debt;
    logic              w_overflow;
    logic              w_ref_dec;
    logic              w_debt_full;

    assign w_ref_dec   = ref_done && r_ref_gnt;
    assign w_debt_full = (w_debt == DEBT_W'(MAX_DEBT));

    refresh_timer #(
        .REFI_CYCLES (REFI_CYCLES),
        .MAX_DEBT    (MAX_DEBT)
    ) u_timer (
        .CLK        (CLK),
        .RST        (RST),
        .i_enable   (init_done),
        .i_dec      (w_ref_dec),
        .o_debt     (w_debt),
        .o_overflow (w_overflow)
    );

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_IDLE: begin
                // Full debt outranks Zorro; otherwise Zorro outranks owed refresh.
                if (init_done) begin
                    if (w_debt_full) begin
                        w_state_next = ST_REFRESH;
                    end else if (zr_req) begin
                        w_state_next = ST_ZORRO;
                    end else if (w_debt != '0) begin
                        w_state_next = ST_REFRESH;
                    end
                end
            end
            ST_ZORRO: begin
                if (zr_done) begin
                    w_state_next = ST_IDLE;
                end
            end
            ST_REFRESH: begin
                if (ref_done) begin
                    w_state_next = ST_IDLE;
                end
            end
            default: begin
                w_state_next = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_state   <= ST_IDLE;
            r_zr_gnt  <= 1'b0;
            r_ref_gnt <= 1'b0;
        end else begin
            r_state   <= w_state_next;
            r_zr_gnt  <= (w_state_next == ST_ZORRO);
            r_ref_gnt <= (w_state_next == ST_REFRESH);
        end
    end

    assign zr_gnt   = r_zr_gnt;
    assign ref_gnt  = r_ref_gnt;
    assign debt     = w_debt;
    assign overflow = w_overflow;

endmodule

// File: tb/tb_refresh_arbiter.sv
// Directed testbench for refresh_arbiter with REFI_CYCLES=16, MAX_DEBT=8.
// Inputs change and outputs are sampled on the falling clock edge.
module tb_refresh_arbiter;

    logic       CLK;
    logic       RST;
    logic       init_done;
    logic       zr_req;
    logic       zr_done;
    logic       ref_done;
    logic       zr_gnt;
    logic       ref_gnt;
    logic [3:0] debt;
    logic       overflow;

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;

    refresh_arbiter #(
        .REFI_CYCLES (16),
        .MAX_DEBT    (8)
    ) dut (
        .CLK       (CLK),
        .RST       (RST),
        .init_done (init_done),
        .zr_req    (zr_req),
        .zr_done   (zr_done),
        .ref_done  (ref_done),
        .zr_gnt    (zr_gnt),
        .ref_gnt   (ref_gnt),
        .debt      (debt),
        .overflow  (overflow)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic step(input int n);
        repeat (n) @(negedge CLK);
        cyc += n;
    endtask

    task automatic step_to(input int k);
        if (k > cyc) step(k - cyc);
    endtask

    // Reset, then release at a falling edge with init_done=1; cycle 0 is that edge.
    task automatic do_reset(input logic req_at_release);
        @(negedge CLK);
        RST = 1'b1; init_done = 1'b0; zr_req = 1'b0; zr_done = 1'b0; ref_done = 1'b0;
        @(negedge CLK);
        RST = 1'b0; init_done = 1'b1; zr_req = req_at_release;
        cyc = 0;
    endtask

    task automatic test_reset;
        @(negedge CLK);
        RST = 1'b1; init_done = 1'b0; zr_req = 1'b1; zr_done = 1'b0; ref_done = 1'b0;
        @(negedge CLK);
        n_tests++;
        if ({zr_gnt, ref_gnt, debt, overflow} !== 7'b0) begin
            n_fail++;
            $display("FAIL reset_state: got gnt=%b%b debt=%0d ovf=%b, expected 00 0 0", zr_gnt, ref_gnt, debt, overflow);
        end
        RST = 1'b0; init_done = 1'b1; zr_req = 1'b0;
        cyc = 0;
        step_to(15);
        n_tests++;
        if ({ref_gnt, debt} !== 5'd0) begin
            n_fail++;
            $display("FAIL reset_pre_tick: got ref_gnt=%b debt=%0d, expected 0 0", ref_gnt, debt);
        end
        step_to(16);
        n_tests++;
        if ({ref_gnt, debt} !== {1'b0, 4'd1}) begin
            n_fail++;
            $display("FAIL reset_first_tick: got ref_gnt=%b debt=%0d, expected 0 1", ref_gnt, debt);
        end
        step_to(17);
        n_tests++;
        if ({zr_gnt, ref_gnt} !== 2'b01) begin
            n_fail++;
            $display("FAIL reset_ref_grant: got gnt=%b%b, expected 01", zr_gnt, ref_gnt);
        end
        zr_done = 1'b1; step(1); zr_done = 1'b0;
        n_tests++;
        if ({ref_gnt, debt} !== {1'b1, 4'd1}) begin
            n_fail++;
            $display("FAIL reset_stray_zr_done: got ref_gnt=%b debt=%0d, expected 1 1", ref_gnt, debt);
        end
        ref_done = 1'b1; step(1); ref_done = 1'b0;
        n_tests++;
        if ({ref_gnt, debt} !== 5'd0) begin
            n_fail++;
            $display("FAIL reset_ref_done: got ref_gnt=%b debt=%0d, expected 0 0", ref_gnt, debt);
        end
        $display("[TB] test_reset done at cycle %0d", cyc);
    endtask

    task automatic test_priority;
        do_reset(1'b1);
        step_to(1);
        n_tests++;
        if ({zr_gnt, ref_gnt} !== 2'b10) begin
            n_fail++;
            $display("FAIL prio_first_zr_gnt: got gnt=%b%b, expected 10", zr_gnt, ref_gnt);
        end
        step_to(10); zr_req = 1'b0;
        step_to(12);
        n_tests++;
        if (zr_gnt !== 1'b1) begin
            n_fail++;
            $display("FAIL prio_req_drop_ignored: got zr_gnt=%b, expected 1", zr_gnt);
        end
        step_to(20); zr_req = 1'b1;
        step_to(30);
        ref_done = 1'b1; step(1); ref_done = 1'b0;
        n_tests++;
        if ({zr_gnt, debt} !== {1'b1, 4'd1}) begin
            n_fail++;
            $display("FAIL prio_stray_ref_done: got zr_gnt=%b debt=%0d, expected 1 1", zr_gnt, debt);
        end
        step_to(48);
        n_tests++;
        if ({zr_gnt, debt} !== {1'b1, 4'd3}) begin
            n_fail++;
            $display("FAIL prio_debt3: got zr_gnt=%b debt=%0d, expected 1 3", zr_gnt, debt);
        end
        zr_done = 1'b1; step(1); zr_done = 1'b0;
        n_tests++;
        if ({zr_gnt, ref_gnt} !== 2'b00) begin
            n_fail++;
            $display("FAIL prio_idle_gap1: got gnt=%b%b, expected 00", zr_gnt, ref_gnt);
        end
        step(1);
        n_tests++;
        if ({zr_gnt, ref_gnt} !== 2'b10) begin
            n_fail++;
            $display("FAIL prio_zorro_first: got gnt=%b%b, expected 10", zr_gnt, ref_gnt);
        end
        zr_req = 1'b0; zr_done = 1'b1; step(1); zr_done = 1'b0;
        n_tests++;
        if ({zr_gnt, ref_gnt} !== 2'b00) begin
            n_fail++;
            $display("FAIL prio_idle_gap2: got gnt=%b%b, expected 00", zr_gnt, ref_gnt);
        end
        step(1);
        n_tests++;
        if ({zr_gnt, ref_gnt} !== 2'b01) begin
            n_fail++;
            $display("FAIL prio_refresh_after: got gnt=%b%b, expected 01", zr_gnt, ref_gnt);
        end
        ref_done = 1'b1; step(1); ref_done = 1'b0;
        n_tests++;
        if ({ref_gnt, debt} !== {1'b0, 4'd2}) begin
            n_fail++;
            $display("FAIL prio_debt_after_ref: got ref_gnt=%b debt=%0d, expected 0 2", ref_gnt, debt);
        end
        $display("[TB] test_priority done at cycle %0d", cyc);
    endtask

    task automatic test_simultaneous;
        do_reset(1'b1);
        step_to(32);
        n_tests++;
        if ({zr_gnt, debt} !== {1'b1, 4'd2}) begin
            n_fail++;
            $display("FAIL sim_setup: got zr_gnt=%b debt=%0d, expected 1 2", zr_gnt, debt);
        end
        zr_req = 1'b0; zr_done = 1'b1; step(1); zr_done = 1'b0;
        step_to(47);
        n_tests++;
        if ({ref_gnt, debt} !== {1'b1, 4'd2}) begin
            n_fail++;
            $display("FAIL sim_ref_held: got ref_gnt=%b debt=%0d, expected 1 2", ref_gnt, debt);
        end
        ref_done = 1'b1; step(1); ref_done = 1'b0;
        n_tests++;
        if ({ref_gnt, debt} !== {1'b0, 4'd2}) begin
            n_fail++;
            $display("FAIL sim_tick_and_done: got ref_gnt=%b debt=%0d, expected 0 2", ref_gnt, debt);
        end
        $display("[TB] test_simultaneous done at cycle %0d", cyc);
    endtask

    task automatic test_urgency;
        logic saw_full;
        logic timeout;
        saw_full = 1'b0;
        timeout  = 1'b0;
        do_reset(1'b1);
        for (int g = 0; g < 60; g++) begin
            int w;
            w = 0;
            while (!(zr_gnt || ref_gnt) && w < 4) begin
                step(1);
                w++;
            end
            if (!(zr_gnt || ref_gnt)) begin
                timeout = 1'b1;
                break;
            end
            if (ref_gnt) break;
            step(1);
            if (zr_gnt && debt == 4'd8) saw_full = 1'b1;
            zr_done = 1'b1; step(1); zr_done = 1'b0;
        end
        n_tests++;
        if (timeout !== 1'b0) begin
            n_fail++;
            $display("FAIL urg_grant_timeout: got timeout=%b, expected 0", timeout);
        end
        n_tests++;
        if ({zr_req, zr_gnt, ref_gnt, debt} !== {3'b101, 4'd8}) begin
            n_fail++;
            $display("FAIL urg_refresh_grant: got req=%b gnt=%b%b debt=%0d, expected 1 01 8", zr_req, zr_gnt, ref_gnt, debt);
        end
        n_tests++;
        if (cyc !== 130) begin
            n_fail++;
            $display("FAIL urg_refresh_cycle: got cycle %0d, expected 130", cyc);
        end
        n_tests++;
        if (saw_full !== 1'b1) begin
            n_fail++;
            $display("FAIL urg_no_preempt: got saw_full=%b, expected 1", saw_full);
        end
        $display("[TB] test_urgency done at cycle %0d", cyc);
    endtask

    // Continues from test_urgency: REFRESH granted at debt 8, zr_req still high.
    task automatic test_overflow;
        step_to(143);
        n_tests++;
        if ({ref_gnt, debt, overflow} !== {1'b1, 4'd8, 1'b0}) begin
            n_fail++;
            $display("FAIL ovf_before: got ref_gnt=%b debt=%0d ovf=%b, expected 1 8 0", ref_gnt, debt, overflow);
        end
        step_to(144);
        n_tests++;
        if ({debt, overflow} !== {4'd8, 1'b1}) begin
            n_fail++;
            $display("FAIL ovf_set: got debt=%0d ovf=%b, expected 8 1", debt, overflow);
        end
        ref_done = 1'b1; step(1); ref_done = 1'b0;
        n_tests++;
        if ({ref_gnt, debt, overflow} !== {1'b0, 4'd7, 1'b1}) begin
            n_fail++;
            $display("FAIL ovf_after_ref: got ref_gnt=%b debt=%0d ovf=%b, expected 0 7 1", ref_gnt, debt, overflow);
        end
        step(1);
        n_tests++;
        if ({zr_gnt, ref_gnt, overflow} !== 3'b101) begin
            n_fail++;
            $display("FAIL ovf_sticky_zorro: got gnt=%b%b ovf=%b, expected 10 1", zr_gnt, ref_gnt, overflow);
        end
        zr_req = 1'b0; zr_done = 1'b1; step(1); zr_done = 1'b0;
        $display("[TB] test_overflow done at cycle %0d", cyc);
    endtask

    task automatic test_mid_reset;
        int bad;
        do_reset(1'b1);
        step_to(80);
        n_tests++;
        if ({zr_gnt, debt} !== {1'b1, 4'd5}) begin
            n_fail++;
            $display("FAIL midrst_setup: got zr_gnt=%b debt=%0d, expected 1 5", zr_gnt, debt);
        end
        step_to(82);
        RST = 1'b1; init_done = 1'b0;
        #1;
        n_tests++;
        if ({zr_gnt, ref_gnt, debt, overflow} !== 7'b0) begin
            n_fail++;
            $display("FAIL midrst_async_clear: got gnt=%b%b debt=%0d ovf=%b, expected 00 0 0", zr_gnt, ref_gnt, debt, overflow);
        end
        step(1);
        RST = 1'b0;
        bad = 0;
        for (int i = 0; i < 20; i++) begin
            step(1);
            if (zr_gnt || ref_gnt || debt != 4'd0) bad++;
        end
        n_tests++;
        if (bad !== 0) begin
            n_fail++;
            $display("FAIL midrst_no_grant_uninit: got %0d bad cycles, expected 0", bad);
        end
        init_done = 1'b1; step(1);
        n_tests++;
        if ({zr_gnt, ref_gnt} !== 2'b10) begin
            n_fail++;
            $display("FAIL midrst_grant_after_init: got gnt=%b%b, expected 10", zr_gnt, ref_gnt);
        end
        $display("[TB] test_mid_reset done at cycle %0d", cyc);
    endtask

    initial begin
        RST = 1'b1; init_done = 1'b0; zr_req = 1'b0; zr_done = 1'b0; ref_done = 1'b0;
        test_reset();
        test_priority();
        test_simultaneous();
        test_urgency();
        test_overflow();
        test_mid_reset();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation still running at %0t, expected completion", $time);
        $fatal(1);
    end

endmodule
